// File: rtl/loader_pkg.sv
// loader_pkg: constants and state encodings shared by the UART program loader
// and its receiver.
//   SYNC_BYTE            - first byte of every frame.
//   DEFAULT_CLKS_PER_BIT - 12 MHz system clock at 115200 baud.
//   loader_state_e       - frame-level FSM states.
//   rx_state_e           - byte-level receiver states.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE            = 8'hA5;
  localparam int         DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, line idles high.
//   clk      - system clock (rising edge)
//   reset    - asynchronous active-high reset
//   rxd      - asynchronous serial input
//   rx_byte  - last received byte, valid while rx_valid is high
//   rx_valid - one-cycle strobe: byte received with a good stop bit
//   rx_ferr  - one-cycle strobe: stop bit sampled low, byte discarded
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state_q, state_d;
  logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        // Edge, not level: a line still low after a framing error must not
        // retrigger.
        if (rxd_prev_q && !rxd_sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Back to idle at mid-stop so a following start edge is never missed.
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = rxd_sync_q;
          ferr_d  = !rxd_sync_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte  = shift_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a framed program image over UART and writes
// it word by word into instruction RAM, holding the CPU in reset until a
// checksum-verified image is loaded.
// Frame: A5, N (0 => 2**DEPTH_I words), N*4 little-endian data bytes, C.
//   clk       - system clock (rising edge)
//   reset     - asynchronous active-high reset
//   uart_rxd  - serial input, 8N1
//   ram_we    - one-cycle instruction RAM write strobe
//   ram_addr  - write address (modulo 2**DEPTH_I)
//   ram_data  - write data
//   cpu_reset - holds the CPU in reset unless the last load succeeded
//   done      - last load succeeded
//   error     - last load failed (checksum, framing or timeout)
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH_I        = 8,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               uart_rxd,
  output logic               ram_we,
  output logic [DEPTH_I-1:0] ram_addr,
  output logic [31:0]        ram_data,
  output logic               cpu_reset,
  output logic               done,
  output logic               error
);

  // Word counter must hold both 255 and 2**DEPTH_I.
  localparam int              WL_W       = ((DEPTH_I > 8) ? DEPTH_I : 8) + 1;
  localparam logic [WL_W-1:0] FULL_WORDS = WL_W'(2**DEPTH_I);
  localparam int              GAP_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rxd      (uart_rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  loader_state_e      state_q, state_d;
  logic [7:0]         acc_q, acc_d;
  logic [WL_W-1:0]    words_left_q, words_left_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        word_q, word_d;
  logic [DEPTH_I-1:0] wr_addr_q, wr_addr_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               ram_we_q, ram_we_d;
  logic [DEPTH_I-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]        ram_data_q, ram_data_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [7:0]         acc_sum;
  logic               in_frame, timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      wr_addr_q    <= '0;
      gap_q        <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      words_left_q <= words_left_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      wr_addr_q    <= wr_addr_d;
      gap_q        <= gap_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    words_left_d = words_left_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    wr_addr_d    = wr_addr_q;
    gap_d        = gap_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    cpu_reset_d  = cpu_reset_q;
    done_d       = done_q;
    error_d      = error_q;
    acc_sum      = acc_q + rx_byte;
    in_frame     = (state_q == ST_COUNT) || (state_q == ST_DATA) ||
                   (state_q == ST_CHECK);
    timeout_hit  = (gap_q == GAP_LAST);

    // Saturating gap counter; reaching the last value means this edge is the
    // TIMEOUT_CYCLES-th since the most recent byte.
    if (rx_valid || rx_ferr) gap_d = '0;
    else if (!timeout_hit)   gap_d = gap_q + 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d     = ST_COUNT;
          done_d      = 1'b0;
          error_d     = 1'b0;
          cpu_reset_d = 1'b1;
        end
      end
      ST_COUNT: begin
        if (rx_valid) begin
          acc_d        = rx_byte;
          words_left_d = (rx_byte == 8'h00) ? FULL_WORDS : WL_W'(rx_byte);
          wr_addr_d    = '0;
          byte_idx_d   = '0;
          state_d      = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          acc_d      = acc_sum;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = rx_byte;
            2'd1: word_d[15:8]  = rx_byte;
            2'd2: word_d[23:16] = rx_byte;
            default: begin
              ram_we_d     = 1'b1;
              ram_addr_d   = wr_addr_q;
              ram_data_d   = {rx_byte, word_q};
              wr_addr_d    = wr_addr_q + 1'b1;
              words_left_d = words_left_q - 1'b1;
              if (words_left_q == WL_W'(1)) state_d = ST_CHECK;
            end
          endcase
        end
      end
      ST_CHECK: begin
        if (rx_valid) begin
          if (acc_sum == 8'h00) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte arriving on the timeout edge still counts as arriving in time.
    if (in_frame && (rx_ferr || (timeout_hit && !rx_valid))) begin
      state_d     = ST_ERROR;
      error_d     = 1'b1;
      cpu_reset_d = 1'b1;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: directed scenarios plus
// randomized frames, all checked against a frame-level model.
module tb_uart_program_loader;
  import loader_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 1000;
  localparam int NWMAX = 1 << DEPTH;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [DEPTH-1:0] addr;
    logic [31:0]      data;
  } wr_t;
  typedef wr_t wr_q_t[$];

  logic             clk = 1'b0;
  logic             reset;
  logic             uart_rxd;
  logic             ram_we;
  logic [DEPTH-1:0] ram_addr;
  logic [31:0]      ram_data;
  logic             cpu_reset, done, error;

  int    tests = 0;
  int    fails = 0;
  wr_t   exp_q[$];
  bit    mon_en = 1'b0;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLKS_PER_BIT  (CPB),
    .DEPTH_I       (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rxd (uart_rxd),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .cpu_reset(cpu_reset),
    .done     (done),
    .error    (error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: writes and final status follow directly from the bytes.
  task automatic model_frame(input byte_q_t f, output wr_q_t w, output bit ok);
    int n, words, sum;
    w = {};
    n = int'(f[1]);
    words = (n == 0) ? NWMAX : n;
    sum = n;
    for (int i = 0; i < words; i++) begin
      wr_t e;
      e.addr = DEPTH'(i % NWMAX);
      e.data = {f[2+4*i+3], f[2+4*i+2], f[2+4*i+1], f[2+4*i]};
      w.push_back(e);
      for (int k = 0; k < 4; k++) sum += int'(f[2+4*i+k]);
    end
    sum += int'(f[2+4*words]);
    ok = (sum % 256) == 0;
  endtask

  function automatic byte_q_t make_frame(input int n, input bit bad);
    byte_q_t f;
    int words, sum;
    logic [7:0] c;
    f = {SYNC_BYTE, 8'(n)};
    words = (n == 0) ? NWMAX : n;
    sum = n;
    for (int i = 0; i < 4 * words; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      f.push_back(b);
      sum += int'(b);
    end
    c = 8'((256 - sum % 256) % 256);
    if (bad) c = c + 8'($urandom_range(1, 255));
    f.push_back(c);
    return f;
  endfunction

  // Inputs change 1 time unit after a rising edge.
  task automatic send_bit(input logic v);
    uart_rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rxd = 1'b1;
  endtask

  task automatic idle(input int cycles);
    uart_rxd = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input bit exp_done);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, !exp_done);
    check({tag, "_cpu_reset"}, cpu_reset, !exp_done);
  endtask

  task automatic run_frame(input string tag, input byte_q_t f, input int max_gap);
    wr_q_t w;
    bit ok;
    model_frame(f, w, ok);
    foreach (w[i]) exp_q.push_back(w[i]);
    foreach (f[i]) begin
      send_byte(f[i], 1'b1);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
    idle(4);
    check_status(tag, ok);
    check({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ram_we"}, ram_we, 1'b0);
    check({tag, "_ram_addr"}, ram_addr, '0);
    check({tag, "_ram_data"}, ram_data, 32'h0);
    check({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
  endtask

  // Compare process: every RAM write against the model queue, plus the
  // status invariants, on every falling edge outside reset.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("cpu_reset_is_not_done", cpu_reset, !done);
      check("done_error_exclusive", done & error, 1'b0);
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h, expected no write",
                   ram_addr, ram_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", ram_addr, e.addr);
          check("write_data", ram_data, e.data);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t good, bad, f;
    wr_q_t   w;
    bit      ok, seen;
    int      lat;
    logic [7:0] d[5];

    reset    = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    mon_en = 1'b1;
    idle(4);

    // Good frame, with the model pinned against hand-computed values.
    good = {8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00,
            8'hFF, 8'h00, 8'h00, 8'h00, 8'hFE};
    model_frame(good, w, ok);
    check("model_good_nwrites", w.size(), 2);
    check("model_good_w0", w[0], {4'd0, 32'h0000_0001});
    check("model_good_w1", w[1], {4'd1, 32'h0000_00FF});
    check("model_good_ok", ok, 1'b1);
    run_frame("good", good, 0);

    // Bad checksum: same writes, then error.
    bad = good;
    bad[10] = 8'h00;
    model_frame(bad, w, ok);
    check("model_bad_ok", ok, 1'b0);
    run_frame("badsum", bad, 0);

    // Leading garbage and a false start are ignored.
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'hFF, 1'b1);
    uart_rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(3 * CPB);
    check("garbage_keeps_error", error, 1'b1);
    run_frame("after_garbage", good, 0);

    // Framing error on the 3rd data byte.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    idle(4 * CPB);
    check_status("ferr", 1'b0);
    run_frame("ferr_recover", good, 0);

    // Timeout after 3 data bytes.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    seen = 1'b0;
    lat = 0;
    for (int c = 0; c < TMO + 200 && !seen; c++) begin
      @(negedge clk);
      lat = c;
      if (error) seen = 1'b1;
    end
    check("timeout_seen", seen, 1'b1);
    check("timeout_in_window", (lat >= TMO - 100) && (lat <= TMO), 1'b1);
    check("timeout_cpu_reset", cpu_reset, 1'b1);
    check("timeout_done", done, 1'b0);

    // Reload after done: cpu_reset rises with the A5 stop-bit sample.
    run_frame("pre_reload", make_frame(3, 1'b0), CPB);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(SYNC_BYTE[i]);
    check("reload_before_stop", cpu_reset, 1'b0);
    send_bit(1'b1);
    check("reload_cpu_reset", cpu_reset, 1'b1);
    check("reload_done_cleared", done, 1'b0);
    send_byte(8'h03, 1'b1);
    for (int i = 0; i < 5; i++) begin
      d[i] = 8'($urandom_range(0, 255));
      if (i == 3) exp_q.push_back({4'd0, d[3], d[2], d[1], d[0]});
      send_byte(d[i], 1'b1);
    end
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    check("mid_reset_writes_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);
    run_frame("post_reset", make_frame(4, 1'b0), CPB);

    // Randomized frames, including address wrap and N = 0.
    for (int r = 0; r < 4; r++) begin
      f = make_frame($urandom_range(1, 20), ($urandom_range(0, 2) == 0));
      run_frame("random", f, CPB);
    end
    run_frame("n_zero", make_frame(0, 1'b0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
